// File: rtl/branch_resolver.sv
// branch_resolver: EX-stage branch outcome, mispredict detection and one-cycle flush record; optional counters under BRANCH_STATS_EN
module branch_resolver #(
    parameter int XLEN       = 32,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PL_stall,
    input  logic                  B_type_ex,
    input  logic                  beq_ex,
    input  logic                  bne_ex,
    input  logic                  blt_ex,
    input  logic                  bge_ex,
    input  logic                  bltu_ex,
    input  logic                  bgeu_ex,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [XLEN-1:0]       pc_ex,
    input  logic [XLEN-1:0]       imme_ex,
    input  logic                  prediction_ex,
    output logic                  resolve_en,
    output logic                  corrected_result,
    output logic                  PL_flush,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  B_type_branch_failed,
    output logic                  beq_branch_failed,
    output logic                  bne_branch_failed,
    output logic                  blt_branch_failed,
    output logic                  bge_branch_failed,
    output logic                  bltu_branch_failed,
    output logic                  bgeu_branch_failed,
    output logic [XLEN-1:0]       pc_branch_filled,
    output logic                  B_type_result_branch_failed,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state_q, state_d;
    logic            eq, lt_s, lt_u, outcome, squash, mispredict;
    logic [XLEN-1:0] target;
    logic [6:0]      kind_q;
    logic            result_q;
    logic [XLEN-1:0] pc_q, redirect_q;

    // Evaluate the branch condition and its fetch target over the full operand width
    always_comb begin
        eq         = rs1_data == rs2_data;
        lt_s       = $signed(rs1_data) < $signed(rs2_data);
        lt_u       = rs1_data < rs2_data;
        outcome    = (beq_ex & eq) | (bne_ex & !eq) | (blt_ex & lt_s) |
                     (bge_ex & !lt_s) | (bltu_ex & lt_u) | (bgeu_ex & !lt_u);
        target     = outcome ? pc_ex + imme_ex : pc_ex + XLEN'(4);
        squash     = state_q == FLUSH;
        resolve_en = B_type_ex & !PL_stall & !squash;
        mispredict = resolve_en & (outcome != prediction_ex);
        state_d    = mispredict ? FLUSH : IDLE;
    end

    assign corrected_result = outcome;

    // State register and failed-branch record, loaded only on a mispredict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            kind_q     <= '0;
            result_q   <= 1'b0;
            pc_q       <= '0;
            redirect_q <= '0;
        end else begin
            state_q <= state_d;
            if (mispredict) begin
                kind_q     <= {B_type_ex, beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex};
                result_q   <= outcome;
                pc_q       <= pc_ex;
                redirect_q <= target;
            end
        end
    end

    assign PL_flush                    = state_q == FLUSH;
    assign {B_type_branch_failed, beq_branch_failed, bne_branch_failed, blt_branch_failed,
            bge_branch_failed, bltu_branch_failed, bgeu_branch_failed} = kind_q & {7{PL_flush}};
    assign pc_branch_filled            = pc_q;
    assign redirect_pc                 = redirect_q;
    assign B_type_result_branch_failed = result_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_WIDTH-1:0] branches_q, mispredicts_q;

    // Saturating resolve and mispredict counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (resolve_en && !(&branches_q)) branches_q <= branches_q + 1'b1;
            if (mispredict && !(&mispredicts_q)) mispredicts_q <= mispredicts_q + 1'b1;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: table vectors, directed corner sequences and randomized run against a spec-level model
module tb_branch_resolver;
    localparam int XLEN = 32;
    localparam int SW   = 4;
    localparam int SMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic PL_stall = 1'b0, B_type_ex = 1'b0, prediction_ex = 1'b0;
    logic beq_ex = 1'b0, bne_ex = 1'b0, blt_ex = 1'b0, bge_ex = 1'b0, bltu_ex = 1'b0, bgeu_ex = 1'b0;
    logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, pc_ex = '0, imme_ex = '0;
    logic resolve_en, corrected_result, PL_flush;
    logic [XLEN-1:0] redirect_pc, pc_branch_filled;
    logic B_type_branch_failed, beq_branch_failed, bne_branch_failed, blt_branch_failed;
    logic bge_branch_failed, bltu_branch_failed, bgeu_branch_failed, B_type_result_branch_failed;
    logic [SW-1:0] stat_branches, stat_mispredicts;

    branch_resolver #(.XLEN(XLEN), .STAT_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .B_type_ex(B_type_ex),
        .beq_ex(beq_ex), .bne_ex(bne_ex), .blt_ex(blt_ex), .bge_ex(bge_ex),
        .bltu_ex(bltu_ex), .bgeu_ex(bgeu_ex), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc_ex(pc_ex), .imme_ex(imme_ex), .prediction_ex(prediction_ex),
        .resolve_en(resolve_en), .corrected_result(corrected_result), .PL_flush(PL_flush),
        .redirect_pc(redirect_pc), .B_type_branch_failed(B_type_branch_failed),
        .beq_branch_failed(beq_branch_failed), .bne_branch_failed(bne_branch_failed),
        .blt_branch_failed(blt_branch_failed), .bge_branch_failed(bge_branch_failed),
        .bltu_branch_failed(bltu_branch_failed), .bgeu_branch_failed(bgeu_branch_failed),
        .pc_branch_filled(pc_branch_filled),
        .B_type_result_branch_failed(B_type_result_branch_failed),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int kcode = 6;

    // reference model state
    bit m_flush = 1'b0;
    logic [6:0] m_kind = '0;
    logic [XLEN-1:0] m_pc = '0, m_redir = '0;
    bit m_res = 1'b0;
    int m_br = 0, m_mp = 0;

    typedef struct {
        int kind;
        logic [XLEN-1:0] a, b, pc, imm;
        bit pred, exp_res, exp_flush;
        logic [XLEN-1:0] exp_redir;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit ref_out(int k, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (k)
            0: return a == b;
            1: return a != b;
            2: return $signed(a) < $signed(b);
            3: return !($signed(a) < $signed(b));
            4: return a < b;
            5: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(int v);
        return v > SMAX ? SMAX : v;
    endfunction

    task automatic set_in(bit b, int k, logic [XLEN-1:0] a, logic [XLEN-1:0] bb,
                          logic [XLEN-1:0] pc, logic [XLEN-1:0] imm, bit pred, bit stall);
        logic [5:0] oh;
        oh = (k < 6) ? (6'b100000 >> k) : 6'b0;
        kcode = k;
        B_type_ex = b;
        {beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex} = oh;
        rs1_data = a; rs2_data = bb; pc_ex = pc; imme_ex = imm;
        prediction_ex = pred; PL_stall = stall;
    endtask

    task automatic idle();
        set_in(1'b0, 6, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_regs();
        chk("PL_flush", PL_flush, m_flush);
        chk("redirect_pc", redirect_pc, m_redir);
        chk("pc_branch_filled", pc_branch_filled, m_pc);
        chk("result_branch_failed", B_type_result_branch_failed, m_res);
        chk("kind_branch_failed", {B_type_branch_failed, beq_branch_failed, bne_branch_failed,
            blt_branch_failed, bge_branch_failed, bltu_branch_failed, bgeu_branch_failed},
            m_flush ? m_kind : 7'd0);
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, sat(m_br));
        chk("stat_mispredicts", stat_mispredicts, sat(m_mp));
`else
        chk("stat_branches", stat_branches, 0);
        chk("stat_mispredicts", stat_mispredicts, 0);
`endif
    endtask

    // one clock: check combinational outputs, advance model at the edge, check registered outputs
    task automatic tick();
        bit res, rsv, mp;
        logic [XLEN-1:0] tgt;
        logic [5:0] oh;
        #3;
        res = ref_out(kcode, rs1_data, rs2_data);
        rsv = B_type_ex && !PL_stall && !m_flush;
        mp  = rsv && (res != prediction_ex);
        tgt = res ? pc_ex + imme_ex : pc_ex + 32'd4;
        oh  = (kcode < 6) ? (6'b100000 >> kcode) : 6'b0;
        chk("resolve_en", resolve_en, rsv);
        if (B_type_ex) chk("corrected_result", corrected_result, res);
        @(posedge clk); #1;
        if (rsv) m_br++;
        if (mp) begin
            m_mp++;
            m_kind = {1'b1, oh};
            m_pc = pc_ex; m_redir = tgt; m_res = res;
        end
        m_flush = mp;
        chk_regs();
    endtask

    task automatic model_reset();
        m_flush = 0; m_kind = '0; m_pc = '0; m_redir = '0; m_res = 0; m_br = 0; m_mp = 0;
    endtask

    initial begin
        int br0;
        vecs.push_back('{1, 32'd5, 32'd5, 32'h100, 32'h20, 1, 0, 1, 32'h104});
        vecs.push_back('{2, 32'hFFFFFFFF, 32'd1, 32'h180, 32'h40, 1, 1, 0, 32'h0});
        vecs.push_back('{4, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1, 0, 1, 32'h204});
        vecs.push_back('{0, 32'd7, 32'd7, 32'h300, 32'h40, 0, 1, 1, 32'h340});
        vecs.push_back('{3, 32'h80000000, 32'd0, 32'h400, 32'h8, 1, 0, 1, 32'h404});
        vecs.push_back('{5, 32'h80000000, 32'd0, 32'h480, 32'h8, 1, 1, 0, 32'h0});
        vecs.push_back('{0, 32'd1, 32'd1, 32'hFFFFFFF0, 32'h20, 0, 1, 1, 32'h10});
        vecs.push_back('{6, 32'd1, 32'd1, 32'h500, 32'h20, 1, 0, 1, 32'h504});
        vecs.push_back('{2, 32'd3, 32'd3, 32'h600, 32'h20, 0, 0, 0, 32'h0});

        idle();
        #2;
        chk_regs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // table vectors, each followed by an idle cycle so any flush clears
        foreach (vecs[i]) begin
            set_in(1'b1, vecs[i].kind, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm, vecs[i].pred, 1'b0);
            #2;
            chk($sformatf("vec%0d_resolve", i), resolve_en, 1);
            chk($sformatf("vec%0d_result", i), corrected_result, vecs[i].exp_res);
            tick();
            chk($sformatf("vec%0d_flush", i), PL_flush, vecs[i].exp_flush);
            if (vecs[i].exp_flush) chk($sformatf("vec%0d_redirect", i), redirect_pc, vecs[i].exp_redir);
            idle();
            tick();
            chk($sformatf("vec%0d_flush_drop", i), PL_flush, 0);
        end

        // back-to-back mispredicts: second one squashed
        set_in(1'b1, 1, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 0, 32'd1, 32'd2, 32'h104, 32'h20, 1'b1, 1'b0);
        #2;
        chk("b2b_squash_resolve", resolve_en, 0);
        chk("b2b_first_flush", PL_flush, 1);
        chk("b2b_bne_failed", bne_branch_failed, 1);
        tick();
        chk("b2b_no_second_flush", PL_flush, 0);
        idle();
        tick();

        // stalled mispredicting beq
        br0 = m_br;
        set_in(1'b1, 0, 32'd9, 32'd9, 32'h700, 32'h10, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_flush", PL_flush, 0);
        end
        PL_stall = 1'b0;
        tick();
        chk("stall_release_flush", PL_flush, 1);
        chk("stall_redirect", redirect_pc, 32'h710);
`ifdef BRANCH_STATS_EN
        chk("stall_stat_once", stat_branches, sat(br0 + 1));
`endif
        idle();
        tick();

        // wrap target then asynchronous reset during FLUSH
        set_in(1'b1, 0, 32'd1, 32'd1, 32'hFFFFFFF0, 32'h20, 1'b0, 1'b0);
        tick();
        chk("wrap_redirect", redirect_pc, 32'h10);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_flush_drop", PL_flush, 0);
        chk_regs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 20 mispredicts drive the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1, 32'd5, 32'd5, 32'h800, 32'h20, 1'b1, 1'b0);
            tick();
            idle();
            tick();
        end
`ifdef BRANCH_STATS_EN
        chk("stat_mispredict_sat", stat_mispredicts, 15);
`else
        chk("stat_mispredict_off", stat_mispredicts, 0);
`endif

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic [XLEN-1:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 4)) : $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 4)) : $urandom);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 6), a, b, $urandom, $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
